// File: rtl/bus_xfer_ctrl.sv
// Bus master for the shared register bus: queues transfer requests, sequences the
// active-low assert/load strobes, resolves the bus value and flags drive contention.
module bus_xfer_ctrl #(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 4,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SEL_W-1:0]        req_src,
    input  logic [SEL_W-1:0]        req_dst,
    input  logic                    req_imm_en,
    input  logic [WIDTH-1:0]        req_imm,
    input  logic [N_REGS*WIDTH-1:0] drv_data,
    input  logic [N_REGS-1:0]       drv_en,
    output logic [N_REGS-1:0]       assert_bus_n,
    output logic [N_REGS-1:0]       load_bus_n,
    output logic [WIDTH-1:0]        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    contention,
    input  logic                    contention_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = 2 * SEL_W + 1 + WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Entry layout: {imm_en, src, dst, imm}
    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, empty, push, pop;

    logic [1:0]       state_q, state_d;
    logic [ENT_W-1:0] cur_q, cur_d;
    logic [N_REGS-1:0] assert_q, assert_d, load_q, load_d;
    logic             contention_q;

    logic             nxt_imm_en;
    logic [SEL_W-1:0] nxt_src, nxt_dst;
    logic             imm_active;
    logic [WIDTH-1:0] drv_bus;
    logic             any_low, multi_low, contention_set;

    assign full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_imm_en, req_src, req_dst, req_imm};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: state_d = S_LOAD;
            S_LOAD:   state_d = S_DONE;
            S_DONE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ASSERT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) cur_d = fifo_mem[rd_ptr_q];
    end

    assign nxt_imm_en = cur_d[ENT_W-1];
    assign nxt_src    = cur_d[WIDTH+SEL_W +: SEL_W];
    assign nxt_dst    = cur_d[WIDTH +: SEL_W];

    // Strobes are decoded from the next state so they leave a flop cleanly.
    // Out-of-range indices simply match no register.
    always_comb begin
        assert_d = '1;
        load_d   = '1;
        for (int i = 0; i < N_REGS; i++) begin
            if ((state_d == S_ASSERT || state_d == S_LOAD) && !nxt_imm_en &&
                int'(nxt_src) == i) begin
                assert_d[i] = 1'b0;
            end
            if (state_d == S_LOAD && int'(nxt_dst) == i) begin
                load_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            assert_q <= '1;
            load_q   <= '1;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            assert_q <= assert_d;
            load_q   <= load_d;
        end
    end

    assign imm_active = (state_q == S_ASSERT || state_q == S_LOAD) && cur_q[ENT_W-1];

    always_comb begin
        drv_bus   = IDLE_VALUE;
        any_low   = 1'b0;
        multi_low = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (!drv_en[i]) begin
                if (!any_low) drv_bus = drv_data[i*WIDTH +: WIDTH];
                if (any_low) multi_low = 1'b1;
                any_low = 1'b1;
            end
        end
    end

    assign contention_set = multi_low || (imm_active && any_low);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contention_q <= 1'b0;
        end else if (contention_set) begin
            contention_q <= 1'b1;
        end else if (contention_clr) begin
            contention_q <= 1'b0;
        end
    end

    assign bus          = imm_active ? cur_q[WIDTH-1:0] : drv_bus;
    assign assert_bus_n = assert_q;
    assign load_bus_n   = load_q;
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE) || !empty;
    assign contention   = contention_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with four behavioural registers on the bus.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_src, req_dst;
    logic        req_imm_en;
    logic [7:0]  req_imm;
    logic [31:0] drv_data;
    logic [3:0]  drv_en;
    logic [3:0]  assert_bus_n, load_bus_n;
    logic [7:0]  bus;
    logic        busy, done, contention, contention_clr;

    logic [7:0]  regs [4];
    logic        pre_en;
    logic [1:0]  pre_idx;
    logic [7:0]  pre_val;
    logic        force_en;
    logic [3:0]  force_val;
    int          done_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          waits;
    int          base;

    always #5 clk = ~clk;

    bus_xfer_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_src        (req_src),
        .req_dst        (req_dst),
        .req_imm_en     (req_imm_en),
        .req_imm        (req_imm),
        .drv_data       (drv_data),
        .drv_en         (drv_en),
        .assert_bus_n   (assert_bus_n),
        .load_bus_n     (load_bus_n),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .contention     (contention),
        .contention_clr (contention_clr)
    );

    // Registers drive the bus while their assert strobe is low, unless overridden.
    assign drv_en   = force_en ? force_val : assert_bus_n;
    assign drv_data = {regs[3], regs[2], regs[1], regs[0]};

    always @(posedge clk) begin
        if (pre_en) begin
            regs[pre_idx] <= pre_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!load_bus_n[i]) regs[i] <= bus;
            end
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [7:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        tick;
        pre_en  = 1'b0;
    endtask

    task automatic push(input logic [1:0] src, input logic [1:0] dst,
                        input logic imm_en, input logic [7:0] imm);
        req_src    = src;
        req_dst    = dst;
        req_imm_en = imm_en;
        req_imm    = imm;
        req_valid  = 1'b1;
        tick;
        req_valid  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0;
        req_imm_en = 1'b0; req_imm = '0; contention_clr = 1'b0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0; force_en = 1'b0; force_val = '1;
        tick; tick;
        check("rst_assert", 32'(assert_bus_n), 32'hF);
        check("rst_load", 32'(load_bus_n), 32'hF);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_contention", 32'(contention), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_bus", 32'(bus), 32'hFF);
        reset_n = 1'b1;
        tick;
        preload(2'd0, 8'h5A);
        preload(2'd1, 8'h00);
        preload(2'd2, 8'hC3);
        preload(2'd3, 8'h00);

        // Reset in the middle of LOAD for 0 -> 1
        push(2'd0, 2'd1, 1'b0, 8'h00);
        tick;
        check("abort_assert", 32'(assert_bus_n), 32'hE);
        tick;
        check("abort_load_pre", 32'(load_bus_n), 32'hD);
        check("abort_bus_pre", 32'(bus), 32'h5A);
        reset_n = 1'b0;
        #1;
        check("abort_load_rst", 32'(load_bus_n), 32'hF);
        check("abort_assert_rst", 32'(assert_bus_n), 32'hF);
        check("abort_busy", 32'(busy), 32'h0);
        tick;
        reset_n = 1'b1;
        check("abort_reg1", 32'(regs[1]), 32'h00);
        check("abort_empty", 32'(busy), 32'h0);
        tick;

        // Register transfer 2 -> 0
        push(2'd2, 2'd0, 1'b0, 8'h00);
        tick;
        check("x20_e1_assert", 32'(assert_bus_n), 32'hB);
        check("x20_e1_load", 32'(load_bus_n), 32'hF);
        check("x20_e1_done", 32'(done), 32'h0);
        tick;
        check("x20_e2_assert", 32'(assert_bus_n), 32'hB);
        check("x20_e2_load", 32'(load_bus_n), 32'hE);
        check("x20_e2_bus", 32'(bus), 32'hC3);
        tick;
        check("x20_e3_done", 32'(done), 32'h1);
        check("x20_e3_strobes", 32'({assert_bus_n, load_bus_n}), 32'hFF);
        check("x20_reg0", 32'(regs[0]), 32'hC3);
        tick;
        check("x20_e4_done", 32'(done), 32'h0);
        check("x20_e4_busy", 32'(busy), 32'h0);

        // Immediate 3C -> 3
        push(2'd0, 2'd3, 1'b1, 8'h3C);
        tick;
        check("imm_e1_assert", 32'(assert_bus_n), 32'hF);
        check("imm_e1_bus", 32'(bus), 32'h3C);
        tick;
        check("imm_e2_load", 32'(load_bus_n), 32'h7);
        check("imm_e2_assert", 32'(assert_bus_n), 32'hF);
        check("imm_e2_bus", 32'(bus), 32'h3C);
        tick;
        check("imm_reg3", 32'(regs[3]), 32'h3C);
        check("imm_done", 32'(done), 32'h1);
        check("imm_bus_after", 32'(bus), 32'hFF);
        tick;
        check("imm_idle_busy", 32'(busy), 32'h0);
        check("imm_idle_bus", 32'(bus), 32'hFF);
        check("imm_no_contention", 32'(contention), 32'h0);

        // Back-to-back pushes: seventh request waits for a free slot
        base = done_cnt;
        for (int k = 0; k < 7; k++) begin
            req_src    = 2'd0;
            req_dst    = 2'(k % 4);
            req_imm_en = 1'b1;
            req_imm    = 8'(8'h10 + k);
            req_valid  = 1'b1;
            waits = 0;
            while (!req_ready && waits < 20) begin
                tick;
                waits++;
            end
            if (k == 6) check("full_wait_cycles", 32'(waits), 32'd2);
            tick;
            if (k == 5) check("full_ready", 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        waits = 0;
        while (busy && waits < 40) begin
            tick;
            waits++;
        end
        check("drain_cycles", 32'(waits), 32'd14);
        check("burst_done_count", 32'(done_cnt - base), 32'd7);
        check("burst_reg0", 32'(regs[0]), 32'h14);
        check("burst_reg1", 32'(regs[1]), 32'h15);
        check("burst_reg2", 32'(regs[2]), 32'h16);
        check("burst_reg3", 32'(regs[3]), 32'h13);

        // Forced drive conflicts
        force_en  = 1'b1;
        force_val = 4'b1100;
        #1;
        check("cont_bus_lowest", 32'(bus), 32'h14);
        tick;
        check("cont_set", 32'(contention), 32'h1);
        tick;
        check("cont_held", 32'(contention), 32'h1);
        force_val = 4'b1111;
        contention_clr = 1'b1;
        tick;
        check("cont_clr", 32'(contention), 32'h0);
        force_val = 4'b1100;
        tick;
        check("cont_set_dominates", 32'(contention), 32'h1);
        force_val = 4'b1101;
        tick;
        check("cont_clr_single", 32'(contention), 32'h0);
        contention_clr = 1'b0;
        check("cont_bus_reg1", 32'(bus), 32'h15);
        tick;
        check("cont_single_ok", 32'(contention), 32'h0);
        force_en = 1'b0;

        // Self transfer 1 -> 1
        preload(2'd1, 8'h77);
        push(2'd1, 2'd1, 1'b0, 8'h00);
        tick;
        check("self_e1_assert", 32'(assert_bus_n), 32'hD);
        tick;
        check("self_e2_assert", 32'(assert_bus_n), 32'hD);
        check("self_e2_load", 32'(load_bus_n), 32'hD);
        check("self_e2_bus", 32'(bus), 32'h77);
        tick;
        check("self_done", 32'(done), 32'h1);
        check("self_reg1", 32'(regs[1]), 32'h77);
        check("self_no_contention", 32'(contention), 32'h0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
